// File: rtl/csr_counter_register_pkg.sv
// Shared CSR definitions: bus widths and standard counter addresses.
// Latency: n/a (constants only).
// Backpressure: n/a.
package csr_counter_register_pkg;

  localparam int CSR_ADDR_WIDTH = 12;
  localparam int CSR_DATA_WIDTH = 32;

  localparam logic [CSR_ADDR_WIDTH-1:0] MCYCLE    = 12'hB00;
  localparam logic [CSR_ADDR_WIDTH-1:0] MINSTRET  = 12'hB02;
  localparam logic [CSR_ADDR_WIDTH-1:0] MCYCLEH   = 12'hB80;
  localparam logic [CSR_ADDR_WIDTH-1:0] MINSTRETH = 12'hB82;
  localparam logic [CSR_ADDR_WIDTH-1:0] CYCLE     = 12'hC00;
  localparam logic [CSR_ADDR_WIDTH-1:0] INSTRET   = 12'hC02;
  localparam logic [CSR_ADDR_WIDTH-1:0] CYCLEH    = 12'hC80;
  localparam logic [CSR_ADDR_WIDTH-1:0] INSTRETH  = 12'hC82;

endpackage

// File: rtl/csr_address_decode.sv
// Maps a strobed CSR address onto one-hot select lines for the counter halves and aliases.
// Latency: combinational, zero cycles.
// Backpressure: none; CSR strobes are always accepted.
module csr_address_decode
  import csr_counter_register_pkg::*;
#(
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDRESS_LOW  = MCYCLE,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDRESS_HIGH = MCYCLEH,
  parameter bit                        ALIAS_ENABLE = 1'b1,
  parameter logic [CSR_ADDR_WIDTH-1:0] ALIAS_LOW    = CYCLE,
  parameter logic [CSR_ADDR_WIDTH-1:0] ALIAS_HIGH   = CYCLEH
) (
  input  logic                      enable,
  input  logic [CSR_ADDR_WIDTH-1:0] address,
  output logic                      low,
  output logic                      high,
  output logic                      aliasLow,
  output logic                      aliasHigh
);

  // Addresses are distinct by construction, so at most one select is ever high.
  always_comb begin
    low       = enable && (address == ADDRESS_LOW);
    high      = enable && (address == ADDRESS_HIGH);
    aliasLow  = enable && ALIAS_ENABLE && (address == ALIAS_LOW);
    aliasHigh = enable && ALIAS_ENABLE && (address == ALIAS_HIGH);
  end

endmodule

// File: rtl/csr_counter_register.sv
// CSR-mapped WIDTH-bit counter split into 32-bit halves, with optional read-only alias and wrap pulse.
// Latency: reads combinational (pre-edge value); writes and increments visible the next cycle.
// Backpressure: none; writes always accepted and take priority over increments.
module csr_counter_register
  import csr_counter_register_pkg::*;
#(
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDRESS_LOW  = MCYCLE,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDRESS_HIGH = MCYCLEH,
  parameter bit                        ALIAS_ENABLE = 1'b1,
  parameter logic [CSR_ADDR_WIDTH-1:0] ALIAS_LOW    = CYCLE,
  parameter logic [CSR_ADDR_WIDTH-1:0] ALIAS_HIGH   = CYCLEH,
  parameter int                        WIDTH        = 64,
  parameter logic [WIDTH-1:0]          RESET_VALUE  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      csrReadEnable,
  input  logic [CSR_ADDR_WIDTH-1:0] csrReadAddress,
  output logic [CSR_DATA_WIDTH-1:0] csrReadData,
  output logic                      csrRequestOutput,
  input  logic                      csrWriteEnable,
  input  logic [CSR_ADDR_WIDTH-1:0] csrWriteAddress,
  input  logic [CSR_DATA_WIDTH-1:0] csrWriteData,
  input  logic                      countEnable,
  input  logic                      inhibit,
  output logic [WIDTH-1:0]          value,
  output logic                      overflow
);

  // Configuration sanity: the high half must exist and fit in one CSR word,
  // and no two responding addresses may alias each other.
  if (WIDTH < 33 || WIDTH > 64) begin : g_bad_width
    $error("csr_counter_register: WIDTH must be within 33..64");
  end
  if (ADDRESS_LOW == ADDRESS_HIGH) begin : g_bad_addr
    $error("csr_counter_register: ADDRESS_LOW equals ADDRESS_HIGH");
  end
  if (ALIAS_ENABLE && (ALIAS_LOW == ALIAS_HIGH || ALIAS_LOW == ADDRESS_LOW ||
                       ALIAS_LOW == ADDRESS_HIGH || ALIAS_HIGH == ADDRESS_LOW ||
                       ALIAS_HIGH == ADDRESS_HIGH)) begin : g_bad_alias
    $error("csr_counter_register: alias address collides with another address");
  end

  logic [WIDTH-1:0]          count;
  logic                      wrap_pulse;
  logic [CSR_DATA_WIDTH-1:0] high_ext;
  logic rd_low, rd_high, rd_alias_low, rd_alias_high;
  logic wr_low, wr_high, wr_alias_low, wr_alias_high;
  logic increment;

  csr_address_decode #(
    .ADDRESS_LOW (ADDRESS_LOW),
    .ADDRESS_HIGH(ADDRESS_HIGH),
    .ALIAS_ENABLE(ALIAS_ENABLE),
    .ALIAS_LOW   (ALIAS_LOW),
    .ALIAS_HIGH  (ALIAS_HIGH)
  ) u_read_decode (
    .enable   (csrReadEnable),
    .address  (csrReadAddress),
    .low      (rd_low),
    .high     (rd_high),
    .aliasLow (rd_alias_low),
    .aliasHigh(rd_alias_high)
  );

  // The write port reuses the decoder; alias hits are decoded but deliberately dropped.
  csr_address_decode #(
    .ADDRESS_LOW (ADDRESS_LOW),
    .ADDRESS_HIGH(ADDRESS_HIGH),
    .ALIAS_ENABLE(ALIAS_ENABLE),
    .ALIAS_LOW   (ALIAS_LOW),
    .ALIAS_HIGH  (ALIAS_HIGH)
  ) u_write_decode (
    .enable   (csrWriteEnable),
    .address  (csrWriteAddress),
    .low      (wr_low),
    .high     (wr_high),
    .aliasLow (wr_alias_low),
    .aliasHigh(wr_alias_high)
  );

  assign increment = countEnable && !inhibit;

  // Counter state: reset beats write, write beats increment; a write blocks the whole increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= RESET_VALUE;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (wr_low) begin
        count[31:0] <= csrWriteData;
      end else if (wr_high) begin
        count[WIDTH-1:32] <= csrWriteData[WIDTH-33:0];
      end else if (increment) begin
        count      <= count + WIDTH'(1);
        wrap_pulse <= &count;
      end
    end
  end

  // Zero-extend the upper half into a full CSR word.
  always_comb begin
    high_ext                = '0;
    high_ext[WIDTH-33:0]    = count[WIDTH-1:32];
  end

  // Read mux: zero when not selected so the result can be OR-combined with other slaves.
  always_comb begin
    csrRequestOutput = rd_low || rd_high || rd_alias_low || rd_alias_high;
    csrReadData      = '0;
    if (rd_low || rd_alias_low) begin
      csrReadData = count[31:0];
    end else if (rd_high || rd_alias_high) begin
      csrReadData = high_ext;
    end
  end

  assign value    = count;
  assign overflow = wrap_pulse;

endmodule

// File: tb/tb_csr_counter_register.sv
// Self-checking bench for csr_counter_register: 64-bit, 40-bit and alias-disabled instances.
// Latency: reads checked before each edge, state checked 1 time unit after each edge.
// Backpressure: n/a.
module tb_csr_counter_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, re, we, ce, inh;
  logic [11:0] ra, wa;
  logic [31:0] wd;

  logic [31:0] rd [3];
  logic        rq [3];
  logic        ov [3];
  logic [63:0] val_a;
  logic [39:0] val_b;
  logic [63:0] val_c;

  int total = 0;
  int fails = 0;

  // Reference model: each instance is just an integer modulo 2**width.
  logic [63:0] mval  [3];
  logic        movf  [3];
  logic [63:0] mmask [3];
  logic        malias[3];

  csr_counter_register dut_a (
    .clk(clk), .rst(rst),
    .csrReadEnable(re), .csrReadAddress(ra), .csrReadData(rd[0]), .csrRequestOutput(rq[0]),
    .csrWriteEnable(we), .csrWriteAddress(wa), .csrWriteData(wd),
    .countEnable(ce), .inhibit(inh), .value(val_a), .overflow(ov[0])
  );

  csr_counter_register #(.WIDTH(40)) dut_b (
    .clk(clk), .rst(rst),
    .csrReadEnable(re), .csrReadAddress(ra), .csrReadData(rd[1]), .csrRequestOutput(rq[1]),
    .csrWriteEnable(we), .csrWriteAddress(wa), .csrWriteData(wd),
    .countEnable(ce), .inhibit(inh), .value(val_b), .overflow(ov[1])
  );

  csr_counter_register #(.ALIAS_ENABLE(1'b0)) dut_c (
    .clk(clk), .rst(rst),
    .csrReadEnable(re), .csrReadAddress(ra), .csrReadData(rd[2]), .csrRequestOutput(rq[2]),
    .csrWriteEnable(we), .csrWriteAddress(wa), .csrWriteData(wd),
    .countEnable(ce), .inhibit(inh), .value(val_c), .overflow(ov[2])
  );

  function automatic logic [63:0] obs_val(input int k);
    if (k == 0) return val_a;
    if (k == 1) return {24'd0, val_b};
    return val_c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void exp_read(input int k, input logic en, input logic [11:0] a,
                                   output logic [31:0] d, output logic q);
    d = '0;
    q = 1'b0;
    if (en) begin
      if (a == 12'hB00 || (malias[k] && a == 12'hC00)) begin
        q = 1'b1;
        d = mval[k][31:0];
      end else if (a == 12'hB80 || (malias[k] && a == 12'hC80)) begin
        q = 1'b1;
        d = mval[k][63:32];
      end
    end
  endfunction

  // Spec-level next state: integer arithmetic modulo 2**width.
  task automatic model_edge(input int k, input logic r, input logic wen, input logic [11:0] waddr,
                            input logic [31:0] wdat, input logic cen, input logic inb);
    movf[k] = 1'b0;
    if (!r) begin
      mval[k] = '0;
    end else if (wen && waddr == 12'hB00) begin
      mval[k] = (mval[k] & ~64'hFFFF_FFFF) | {32'd0, wdat};
    end else if (wen && waddr == 12'hB80) begin
      mval[k] = (mval[k] & 64'hFFFF_FFFF) | (({32'd0, wdat} << 32) & mmask[k]);
    end else if (cen && !inb) begin
      if (mval[k] == mmask[k]) begin
        mval[k] = '0;
        movf[k] = 1'b1;
      end else begin
        mval[k] = mval[k] + 64'd1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic ren, input logic [11:0] raddr, input logic wen,
                     input logic [11:0] waddr, input logic [31:0] wdat, input logic cen,
                     input logic inb);
    logic [31:0] ed;
    logic        eq;
    rst = r; re = ren; ra = raddr; we = wen; wa = waddr; wd = wdat; ce = cen; inh = inb;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_read(k, ren, raddr, ed, eq);
      check($sformatf("rd_data[%0d] @%h", k, raddr), {32'd0, rd[k]}, {32'd0, ed});
      check($sformatf("rd_req[%0d] @%h", k, raddr), {63'd0, rq[k]}, {63'd0, eq});
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, r, wen, waddr, wdat, cen, inb);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("value[%0d]", k), obs_val(k), mval[k]);
      check($sformatf("overflow[%0d]", k), {63'd0, ov[k]}, {63'd0, movf[k]});
    end
  endtask

  task automatic rd_only(input logic [11:0] a);
    cyc(1'b1, 1'b1, a, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, 12'h000, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  logic [11:0] addr_pool [6];

  initial begin
    mmask[0] = 64'hFFFF_FFFF_FFFF_FFFF; malias[0] = 1'b1;
    mmask[1] = 64'h0000_00FF_FFFF_FFFF; malias[1] = 1'b1;
    mmask[2] = 64'hFFFF_FFFF_FFFF_FFFF; malias[2] = 1'b0;
    addr_pool[0] = 12'hB00; addr_pool[1] = 12'hB80; addr_pool[2] = 12'hC00;
    addr_pool[3] = 12'hC80; addr_pool[4] = 12'h300; addr_pool[5] = 12'hB02;

    // Reset held for two edges.
    rst = 1'b0; re = 1'b0; we = 1'b0; ce = 1'b1; inh = 1'b0; ra = '0; wa = '0; wd = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mval[k] = '0;
      movf[k] = 1'b0;
      check($sformatf("reset_value[%0d]", k), obs_val(k), 64'd0);
      check($sformatf("reset_ovf[%0d]", k), {63'd0, ov[k]}, 64'd0);
    end
    rd_only(12'hB00);
    rd_only(12'hB80);
    rd_only(12'h300);

    // Five counts, then inhibit for three cycles.
    repeat (5) cyc(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    check("count5", val_a, 64'd5);
    rd_only(12'hB00);
    rd_only(12'hC00);
    repeat (3) cyc(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1);
    check("inhibit_hold", val_a, 64'd5);

    // Carry across halves.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    cyc(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    check("carry", val_a, 64'h0000_0001_0000_0000);
    rd_only(12'hB00);
    rd_only(12'hB80);

    // Wrap from all-ones; 40-bit instance keeps only 8 high bits.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF);
    rd_only(12'hB80);
    cyc(1'b1, 1'b1, 12'hC80, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    check("wrap_ovf64", {63'd0, ov[0]}, 64'd1);
    check("wrap_ovf40", {63'd0, ov[1]}, 64'd1);
    cyc(1'b1, 1'b1, 12'hB80, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
    check("ovf_one_cycle", {63'd0, ov[0]}, 64'd0);

    // Write beats increment; same-cycle read sees the old value.
    cyc(1'b1, 1'b1, 12'hB00, 1'b1, 12'hB00, 32'h0000_1234, 1'b1, 1'b0);
    check("write_priority", val_a, 64'h0000_0000_0000_1234);
    rd_only(12'hB00);

    // Alias writes are ignored; alias reads depend on ALIAS_ENABLE.
    wr(12'hC00, 32'hDEAD_BEEF);
    wr(12'hC80, 32'hDEAD_BEEF);
    rd_only(12'hC00);
    rd_only(12'hC80);

    // Reset in a cycle that also writes.
    cyc(1'b0, 1'b1, 12'hB00, 1'b1, 12'hB00, 32'hAAAA_5555, 1'b1, 1'b0);
    rd_only(12'hB00);

    // Randomized traffic, biased toward all-ones writes so wraps occur.
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_we;
      logic [11:0] r_ra, r_wa;
      logic [31:0] r_wd;
      r_rst = ($urandom_range(0, 63) != 0);
      r_we  = ($urandom_range(0, 5) == 0);
      r_ra  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 5)];
      r_wa  = addr_pool[$urandom_range(0, 5)];
      r_wd  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cyc(r_rst, 1'($urandom), r_ra, r_we, r_wa, r_wd,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/csr_counter_register.md
Name: csr_counter_register

Overview:
- Parametrised CSR-mapped counter, WIDTH bits wide, exposed as two 32-bit CSR halves (low/high), e.g. mcycle/mcycleh or minstret/minstreth.
- Successor to the read-only CSR register. Adds a sequential counter, machine-mode writes, inhibit control, an optional read-only alias address pair (e.g. cycle/cycleh) and an overflow pulse.
- Sits in the core CSR block. Its read outputs are OR-combined with other CSR slaves on csrReadData / csrRequestOutput.

Parameters:
- ADDRESS_LOW, 12'hB00, CSR address of bits [31:0]; read/write.
- ADDRESS_HIGH, 12'hB80, CSR address of bits [WIDTH-1:32]; read/write.
- ALIAS_ENABLE, 1, 1 = alias addresses respond to reads; 0 = aliases ignored.
- ALIAS_LOW, 12'hC00, read-only alias of the low half.
- ALIAS_HIGH, 12'hC80, read-only alias of the high half.
- WIDTH, 64, counter width; legal range 33..64.
- RESET_VALUE, 0, counter value after reset (WIDTH bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (counter reset when rst==0 at a rising clk edge)
- csrReadEnable  in  1  read strobe
- csrReadAddress  in  12  read address
- csrReadData  out  32  read data; 0 when not selected
- csrRequestOutput  out  1  high when this block drives csrReadData
- csrWriteEnable  in  1  write strobe
- csrWriteAddress  in  12  write address
- csrWriteData  in  32  write data
- countEnable  in  1  increment request (cycle tick / instruction retired)
- inhibit  in  1  suppresses increments (mcountinhibit bit)
- value  out  WIDTH  full counter value, registered
- overflow  out  1  one-cycle pulse on wrap from all-ones to 0

Behaviour:
- Reset: on a clk edge with rst==0, the counter loads RESET_VALUE and overflow goes to 0. The read path stays combinational, so outputs reflect the reset state from the next cycle.
- Read path (combinational, zero latency):
  - Hit = csrReadEnable && (addr==ADDRESS_LOW || addr==ADDRESS_HIGH || (ALIAS_ENABLE && (addr==ALIAS_LOW || addr==ALIAS_HIGH))).
  - csrRequestOutput = hit.
  - Low address returns value[31:0].
  - High address returns value[WIDTH-1:32], zero-extended to 32 bits.
  - No hit returns 32'b0.
  - Reads show the pre-edge (registered) value, including in a cycle that also writes.
- Write path (registered, effective next cycle):
  - csrWriteEnable with addr==ADDRESS_LOW replaces bits [31:0]; upper bits unchanged.
  - Write to ADDRESS_HIGH replaces [WIDTH-1:32] with csrWriteData[WIDTH-33:0]; the excess data bits are ignored.
  - Writes to alias addresses and to any other address have no effect.
- Increment: when countEnable && !inhibit, counter <= counter + 1, with full WIDTH-bit carry across halves.
- Priority:
  - In a cycle with a valid write, the increment is suppressed entirely (no partial increment of the unwritten half), so a written value is read back exactly.
  - Reset beats write, and write beats increment.
- Wrap: all-ones + 1 gives 0. overflow = 1 for exactly the following cycle. A write never raises overflow.
- Inhibit toggling takes effect in the same cycle it is sampled. No pending increments are remembered.
- Simultaneous read and write of the same address: read returns the old value; the new value is visible next cycle.
- Reset mid-count discards all state; there is no holdover of pending writes.
- Address collisions between parameters are a configuration error. The implementation must fail elaboration if any two enabled addresses are equal, or if WIDTH is outside 33..64.

Decomposition:
- Shared CSR package holds:
  - standard counter address constants (MCYCLE, MCYCLEH, MINSTRET, MINSTRETH, CYCLE, CYCLEH, INSTRET, INSTRETH);
  - CSR address width (12) and data width (32).
- One natural sub-module, csr_address_decode. It maps an address plus enable to one-hot select lines (low, high, aliasLow, aliasHigh) and is reused for the read and write ports.
- The counter and priority logic stay in the top module.

Test Plan:
- Reset with RESET_VALUE=0: hold rst=0 for 2 cycles, release, read 0xB00 and 0xB80 → both 0, csrRequestOutput=1. Read 0x300 → data 0, request 0.
- Count 5 cycles with countEnable=1, inhibit=0 → 0xB00 reads 5 and 0xC00 reads 5. Assert inhibit for 3 cycles → value stays 5.
- Carry: write 0xB00=0xFFFFFFFF, write 0xB80=0, then one increment → low reads 0, high reads 1.
- Wrap, WIDTH=64: write both halves all-ones, one increment → value 0 and overflow high for exactly 1 cycle. Repeat with WIDTH=40 → high read 0x00000000 after wrap, and 0x000000FF before wrap.
- Write priority: countEnable=1 while writing 0xB00=0x1234 → next cycle reads 0x1234, not 0x1235. The same-cycle read returns the old value.
- Alias: write to 0xC00 → counter unchanged. With ALIAS_ENABLE=0, reading 0xC00 → data 0, request 0.
